pio_edge_in: RTL and testbench
==============================

# pio_edge_in

Parametrised Avalon-MM input port for the Nios II system, next generation of the plain PIO input. Adds the following:
- configurable width;
- input synchronisation and per-bit debounce;
- selectable edge capture with per-bit interrupt mask and a level interrupt.

It connects push-buttons, switches and rotary-encoder lines to the CPU without software polling or bounce filtering.

## Interface
Parameters:
- WIDTH, 16, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (2..4)
- DEBOUNCE_CYCLES, 0, consecutive cycles a changed input must hold before acceptance; 0 behaves as 1
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any edge

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data, zero-extended above WIDTH
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  level interrupt to CPU

## Operation
Register map (word address):
- 0 DATA, read-only: debounced value `stable`.
- 1 reserved: reads 0, writes ignored.
- 2 IRQMASK, read/write: bits [WIDTH-1:0].
- 3 EDGECAPTURE, read/write-1-to-clear.

Input path, per bit:
- The bit passes through SYNC_STAGES flops; the last flop is `synced`.
- The debounce counter clears when `synced == stable` and increments when they differ.
- `stable` loads `synced` on the D-th consecutive differing edge, with D = max(DEBOUNCE_CYCLES,1). The counter then clears.
- Counter width is clog2(D+1); the counter never wraps.

Edge capture:
- `prev` is the registered copy of `stable`.
- Event: rising = stable & ~prev; falling = ~stable & prev; any = stable ^ prev.
- An event sets the EDGECAPTURE bit.
- A write to address 3 (chipselect=1, write_n=0) clears bits where writedata=1.
- If set and clear hit the same bit in the same cycle, set wins.

Other register behaviour:
- Write to address 2 loads IRQMASK from writedata[WIDTH-1:0]. Writes to addresses 0 and 1 are ignored.
- irq = |(EDGECAPTURE & IRQMASK), combinational from flops.
- readdata is updated on every clk edge from the address mux, independent of chipselect. Bits above WIDTH are always 0.

## Timing
- Reset: every flop is cleared asynchronously (sync chain, stable, prev, counters, IRQMASK, EDGECAPTURE, readdata). readdata=0 and irq=0 during and after reset.
- in_port settled before edge 1 gives:
  - synced valid after edge SYNC_STAGES;
  - stable updated at edge SYNC_STAGES+D;
  - EDGECAPTURE and irq updated at edge SYNC_STAGES+D+1.
- Read latency is 1 cycle: readdata reflects the register value sampled at the edge where address is presented.
- An EDGECAPTURE write takes effect at the write edge. irq drops in the following cycle unless a new event occurred in the same cycle.
- Bounce shorter than D cycles restarts the counter and produces no stable change and no capture.
- A high input at reset release is treated as a rising edge once debounced. It is captured, but does not interrupt because IRQMASK=0.
- Reset asserted mid-debounce discards the count. There is no partial state after release.

## Structure
- Package `pio_edge_pkg` holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
- Sub-module `pio_debounce_bit` (parameters SYNC_STAGES, DEBOUNCE_CYCLES):
  - inputs clk, reset_n, in;
  - output stable;
  - instantiated WIDTH times by generate.
- The top level holds prev, edge logic, registers, read mux and irq.

## Test plan
All scenarios use WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated.
- Reset: in_port=16'hFFFF held through reset → readdata=0 and irq=0 during reset. DATA reads 0000FFFF by edge 7 after release. EDGECAPTURE reads 0000FFFF, irq stays 0.
- Debounce: bit 3 toggles high for 3 cycles then low → DATA and EDGECAPTURE unchanged. Bit 3 held high 4+ cycles → DATA bit 3 set at edge 6, EDGECAPTURE bit 3 set at edge 7.
- IRQ: write IRQMASK=0x0008, raise bit 3 → irq=1. Write 0x0008 to addr 3 → EDGECAPTURE=0, irq=0 next cycle.
- Simultaneous set/clear: a clear write to addr 3 coincides with a new rising event on the same bit → bit remains 1, irq stays asserted.
- Register map: read addr 1 → 0. Write addr 0 → DATA unaffected. Write IRQMASK=0xFFFFFFFF → reads 0x0000FFFF.
- EDGE_TYPE=2, DEBOUNCE_CYCLES=0: bit 0 high pulse of 2 cycles → EDGECAPTURE bit 0 set, by both the rise and the fall.

Source files
------------

// File: rtl/pio_edge_pkg.sv
// ============================================================================
// pio_edge_pkg : register addresses and edge-type codes for pio_edge_in
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pio_edge_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // A debounce setting of 0 behaves exactly like 1.
  function automatic int debounce_len(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pio_edge_in_if.sv
// ============================================================================
// pio_edge_in_if : Avalon-MM slave bus plus interrupt line for pio_edge_in
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface pio_edge_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

endinterface

`default_nettype wire

// File: rtl/pio_debounce_bit.sv
// ============================================================================
// pio_debounce_bit : synchroniser chain plus consecutive-cycle debounce filter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module pio_debounce_bit
  import pio_edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic stable
);

  localparam int              c_DEB_LEN = debounce_len(DEBOUNCE_CYCLES);
  localparam int              c_CNT_W   = $clog2(c_DEB_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DEB_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_stable;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign stable   = r_stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
    end
  end

  // The count stops at c_CNT_LAST, where stable is loaded, so it cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_synced == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= w_synced;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pio_edge_in.sv
// ============================================================================
// pio_edge_in : debounced Avalon-MM input port with edge capture and irq
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pio_edge_in
  import pio_edge_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  pio_edge_in_if.slave     bus
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_next;
  logic             w_unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in_port[i]),
        .stable  (w_stable[i])
      );
    end
  endgenerate

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
      assign w_event = w_stable & ~r_prev;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign w_event = ~w_stable & r_prev;
    end else begin : g_any
      assign w_event = w_stable ^ r_prev;
    end
  endgenerate

  assign w_wr           = bus.chipselect && !bus.write_n;
  assign w_clr          = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^bus.writedata;

  always_comb begin
    w_rd_next = '0;
    case (bus.address)
      ADDR_DATA:    w_rd_next = 32'(w_stable);
      ADDR_IRQMASK: w_rd_next = 32'(r_mask);
      ADDR_EDGECAP: w_rd_next = 32'(r_ecap);
      default:      w_rd_next = '0;
    endcase
  end

  // New events are OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev       <= '0;
      r_mask       <= '0;
      r_ecap       <= '0;
      bus.readdata <= '0;
    end else begin
      r_prev       <= w_stable;
      r_ecap       <= (r_ecap & ~w_clr) | w_event;
      bus.readdata <= w_rd_next;
      if (w_wr && bus.address == ADDR_IRQMASK) begin
        r_mask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  assign bus.irq = |(r_ecap & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_pio_edge_in.sv
// ============================================================================
// tb_pio_edge_in : two configurations driven in parallel against a rule model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_pio_edge_in;

  localparam int W = 16;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_port;
  logic [1:0]  addr;
  logic        cs;
  logic        wn;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_edge_in_if bus0 ();
  pio_edge_in_if bus1 ();

  assign bus0.address = addr;  assign bus1.address = addr;
  assign bus0.chipselect = cs; assign bus1.chipselect = cs;
  assign bus0.write_n = wn;    assign bus1.write_n = wn;
  assign bus0.writedata = wd;  assign bus1.writedata = wd;

  pio_edge_in #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0));

  pio_edge_in #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen S edges ago, run lengths of disagreement.
  logic [15:0] hist[$];
  logic [15:0] m_stable[2], m_prev[2], m_ecap[2], m_mask[2];
  logic [31:0] m_rd[2];
  int          run[2][16];

  function automatic int dlen(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int etype(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_stable[i] = '0; m_prev[i] = '0; m_ecap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
      for (int b = 0; b < 16; b++) run[i][b] = 0;
    end
  endtask

  task automatic model_step();
    logic [15:0] syn, st_o, pv_o, ec_o, mk_o, ev, clr;
    logic        wr;
    syn = (hist.size() >= S) ? hist[S-1] : 16'h0;
    hist.push_front(in_port);
    while (hist.size() > S) void'(hist.pop_back());
    wr  = cs && !wn;
    clr = (wr && addr == 2'd3) ? wd[15:0] : 16'h0;
    for (int i = 0; i < 2; i++) begin
      st_o = m_stable[i]; pv_o = m_prev[i]; ec_o = m_ecap[i]; mk_o = m_mask[i];
      for (int b = 0; b < 16; b++) begin
        if (syn[b] != st_o[b]) begin
          run[i][b]++;
          if (run[i][b] >= dlen(i)) begin
            m_stable[i][b] = syn[b];
            run[i][b] = 0;
          end
        end else begin
          run[i][b] = 0;
        end
      end
      case (etype(i))
        0:       ev = st_o & ~pv_o;
        1:       ev = ~st_o & pv_o;
        default: ev = st_o ^ pv_o;
      endcase
      m_ecap[i] = (ec_o & ~clr) | ev;
      m_prev[i] = st_o;
      if (wr && addr == 2'd2) m_mask[i] = wd[15:0];
      case (addr)
        2'd0:    m_rd[i] = {16'h0, st_o};
        2'd2:    m_rd[i] = {16'h0, mk_o};
        2'd3:    m_rd[i] = {16'h0, ec_o};
        default: m_rd[i] = 32'h0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rd0", bus0.readdata, m_rd[0]);
    chk("rd1", bus1.readdata, m_rd[1]);
    chk("irq0", {31'h0, bus0.irq}, {31'h0, |(m_ecap[0] & m_mask[0])});
    chk("irq1", {31'h0, bus1.irq}, {31'h0, |(m_ecap[1] & m_mask[1])});
  endtask

  task automatic idle();
    cs = 1'b0; wn = 1'b1; wd = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wn = 1'b0; addr = a; wd = d;
    tick();
    idle();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rd0"}, bus0.readdata, 32'h0);
    chk({tag, "_rd1"}, bus1.readdata, 32'h0);
    chk({tag, "_irq0"}, {31'h0, bus0.irq}, 32'h0);
    chk({tag, "_irq1"}, {31'h0, bus1.irq}, 32'h0);
  endtask

  task automatic random_cycles(input int n);
    logic [15:0] flip;
    for (int k = 0; k < n; k++) begin
      flip = '0;
      for (int b = 0; b < 16; b++) flip[b] = ($urandom_range(0, 9) == 0);
      in_port = in_port ^ flip;
      cs   = $urandom_range(0, 1) == 1;
      wn   = $urandom_range(0, 3) != 0;
      addr = 2'($urandom_range(0, 3));
      wd   = $urandom;
      tick();
    end
    idle();
  endtask

  initial begin
    in_port = 16'hFFFF;
    addr = 2'd0;
    idle();
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      reset_checks("in_rst");
    end
    reset_n = 1'b1;

    // High inputs at release: DATA by edge 7, then captured without irq.
    repeat (7) tick();
    chk("data_ffff", bus0.readdata, 32'h0000FFFF);
    addr = 2'd3;
    tick();
    chk("ecap_ffff", bus0.readdata, 32'h0000FFFF);
    chk("ecap_noirq", {31'h0, bus0.irq}, 32'h0);

    in_port = 16'h0;
    repeat (10) tick();
    bus_write(2'd3, 32'hFFFF);

    // Short bounce on bit 3, then a held level.
    in_port = 16'h0008;
    repeat (3) tick();
    in_port = 16'h0;
    repeat (8) tick();
    addr = 2'd0; tick();
    chk("bounce_data", bus0.readdata, 32'h0);
    addr = 2'd3; tick();
    chk("bounce_ecap", bus0.readdata, 32'h0);

    bus_write(2'd2, 32'h0008);
    in_port = 16'h0008;
    repeat (8) tick();
    chk("irq_set", {31'h0, bus0.irq}, 32'h1);
    bus_write(2'd3, 32'h0008);
    tick();
    chk("irq_clr", {31'h0, bus0.irq}, 32'h0);

    // Clear write lands on the same edge as a new rising capture.
    in_port = 16'h0;
    repeat (10) tick();
    bus_write(2'd3, 32'hFFFF);
    in_port = 16'h0008;
    repeat (6) tick();
    bus_write(2'd3, 32'h0008);
    chk("setwins_irq", {31'h0, bus0.irq}, 32'h1);

    // Register map corners.
    addr = 2'd1; repeat (2) tick();
    chk("rsvd_rd", bus0.readdata, 32'h0);
    bus_write(2'd0, 32'h0000FFFF);
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_write(2'd2, 32'hFFFFFFFF);
    addr = 2'd2; repeat (2) tick();
    chk("mask_ext", bus0.readdata, 32'h0000FFFF);

    // Any-edge instance with a 2-cycle pulse on bit 0.
    in_port = 16'h0;
    repeat (8) tick();
    bus_write(2'd3, 32'hFFFF);
    in_port = 16'h0001;
    repeat (2) tick();
    in_port = 16'h0;
    repeat (8) tick();
    addr = 2'd3; tick();

    random_cycles(3000);

    // Asynchronous reset in the middle of activity.
    reset_n = 1'b0;
    #1;
    reset_checks("async_rst");
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      reset_checks("hold_rst");
    end
    reset_n = 1'b1;
    random_cycles(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
